// File: rtl/bcd_dabble_seq.sv
// bcd_dabble_seq
// Iterative binary-to-BCD converter (shift-and-add-3) driving active-low
// seven-segment displays.
//
// Parameters:
//   N       binary input width (4..20)
//   DIGITS  BCD digits / displays driven (1..6)
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     conversion request, accepted only while busy=0
//   bin_in    unsigned binary value, sampled on the accepting edge
//   busy      conversion in progress
//   done      one-cycle pulse, results updated this cycle
//   overflow  last accepted value exceeds 10^DIGITS-1
//   bcd_out   packed BCD digits, units in [3:0]
//   seg_out   active-low segments {g,f,e,d,c,b,a} per digit, units in [6:0]
// Optional feature macro: BCD_LEADING_BLANK_EN
//   When defined, leading zero digits are blanked on seg_out (units digit
//   always shown; overflow dashes take priority; bcd_out unaffected).
module bcd_dabble_seq #(
  parameter int N      = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out
);

  function automatic int dec_digits(input int n);
    int v;
    int d;
    v = (1 << n) - 1;
    d = 0;
    for (int i = 0; i < 10; i++) begin
      if (v > 0) begin
        d++;
        v = v / 10;
      end
    end
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int pow10(input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Scratch covers the full N-bit range so the modulo digits are exact even
  // when DIGITS is smaller than the value needs; never narrower than DIGITS.
  localparam int          SD    = dec_digits(N);
  localparam int          SW    = (SD > DIGITS) ? SD : DIGITS;
  localparam int          CW    = $clog2(N);
  localparam logic [31:0] LIMIT = 32'(pow10(DIGITS) - 1);
  localparam logic [6:0]  BLANK = 7'b1111111;
  localparam logic [6:0]  DASH  = 7'b0111111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic                accept, last;
  logic [CW-1:0]       cnt_p0;
  logic [N-1:0]        bin_p0, bin_nxt;
  logic [4*SW-1:0]     scr_p0, scr_nxt, adj;
  logic [4*SW+N-1:0]   cat;
  logic                ovf_p0;
  logic [7*DIGITS-1:0] seg_nxt;

  assign busy = (state_q == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_p0 == CW'(N - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> next: add-3 correction then one-bit shift of {scratch, binary}
  always_comb begin
    adj = scr_p0;
    for (int i = 0; i < SW; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    cat     = {adj, bin_p0} << 1;
    scr_nxt = cat[4*SW+N-1:N];
    bin_nxt = cat[N-1:0];
  end

  always_comb begin
    logic lead;
    seg_nxt = '1;
    lead    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_p0) begin
        seg_nxt[7*i +: 7] = DASH;
      end else begin
`ifdef BCD_LEADING_BLANK_EN
        if (lead && (i != 0) && (scr_nxt[4*i +: 4] == 4'd0)) begin
          seg_nxt[7*i +: 7] = BLANK;
        end else begin
          lead              = 1'b0;
          seg_nxt[7*i +: 7] = seg7(scr_nxt[4*i +: 4]);
        end
`else
        lead              = 1'b0;
        seg_nxt[7*i +: 7] = seg7(scr_nxt[4*i +: 4]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      bin_p0 <= bin_in;
      scr_p0 <= '0;
      ovf_p0 <= ({{(32-N){1'b0}}, bin_in} > LIMIT);
    end else if (state_q == SHIFT) begin
      bin_p0 <= bin_nxt;
      scr_p0 <= scr_nxt;
    end
  end

  // Output stage: results registered on the final shift
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
      seg_out  <= '1;
    end else begin
      done <= last;
      if (accept)                 cnt_p0 <= '0;
      else if (state_q == SHIFT)  cnt_p0 <= cnt_p0 + 1'b1;
      if (last) begin
        bcd_out  <= scr_nxt[4*DIGITS-1:0];
        overflow <= ovf_p0;
        seg_out  <= seg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bcd_dabble_seq.sv
// Scoreboard bench for bcd_dabble_seq: a DIGITS=4 and a DIGITS=3 instance,
// both N=10. Expected results are queued when a start is issued; a monitor
// pops and compares whenever done is seen.
module tb_bcd_dabble_seq;
  localparam int N = 10;

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0, start3 = 1'b0;
  logic [9:0]  bin4 = '0, bin3 = '0;
  logic        busy4, done4, ovf4, busy3, done3, ovf3;
  logic [15:0] bcd4;
  logic [27:0] seg4;
  logic [11:0] bcd3;
  logic [20:0] seg3;

  bcd_dabble_seq #(.N(N), .DIGITS(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .bin_in(bin4), .busy(busy4),
    .done(done4), .overflow(ovf4), .bcd_out(bcd4), .seg_out(seg4));

  bcd_dabble_seq #(.N(N), .DIGITS(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .bin_in(bin3), .busy(busy3),
    .done(done3), .overflow(ovf3), .bcd_out(bcd3), .seg_out(seg3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] bcd;
    logic [27:0] seg;
    logic        ovf;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic go4(input logic [9:0] v, input logic [15:0] b, input logic [27:0] s);
    exp_t e;
    e.due = cyc + 1 + N; e.bcd = b; e.seg = s; e.ovf = 1'b0;
    q4.push_back(e);
    start4 = 1'b1; bin4 = v;
    @(posedge clk); #1;
    start4 = 1'b0; bin4 = 10'h2AA;
  endtask

  task automatic go3(input logic [9:0] v, input logic [11:0] b, input logic [20:0] s, input logic o);
    exp_t e;
    e.due = cyc + 1 + N; e.bcd = {4'h0, b}; e.seg = {7'h0, s}; e.ovf = o;
    q3.push_back(e);
    start3 = 1'b1; bin3 = v;
    @(posedge clk); #1;
    start3 = 1'b0; bin3 = 10'h155;
  endtask

  task automatic wait_done4(input string name);
    int n;
    n = 0;
    while (!done4 && n < 40) begin @(posedge clk); #1; n++; end
    if (!done4) begin
      tests++; fails++;
      $display("FAIL %s: got no done in 40 cycles, required a done", name);
    end
  endtask

  task automatic wait_done3(input string name);
    int n;
    n = 0;
    while (!done3 && n < 40) begin @(posedge clk); #1; n++; end
    if (!done3) begin
      tests++; fails++;
      $display("FAIL %s: got no done in 40 cycles, required a done", name);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done4) begin
        if (q4.size() == 0) begin
          tests++; fails++;
          $display("FAIL d4_unexpected_done: got done at cycle %0d, required none", cyc);
        end else begin
          e = q4.pop_front();
          check("d4_bcd", 32'(bcd4), 32'(e.bcd));
          check("d4_seg", 32'(seg4), 32'(e.seg));
          check("d4_ovf", 32'(ovf4), 32'(e.ovf));
          check("d4_latency", 32'(cyc), 32'(e.due));
          check("d4_busy_in_done", 32'(busy4), 32'd0);
        end
      end
      if (done3) begin
        if (q3.size() == 0) begin
          tests++; fails++;
          $display("FAIL d3_unexpected_done: got done at cycle %0d, required none", cyc);
        end else begin
          e = q3.pop_front();
          check("d3_bcd", 32'(bcd3), 32'(e.bcd));
          check("d3_seg", 32'(seg3), 32'(e.seg));
          check("d3_ovf", 32'(ovf3), 32'(e.ovf));
          check("d3_latency", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_ovf", 32'(ovf4), 32'd0);
    check("rst_bcd", 32'(bcd4), 32'd0);
    check("rst_seg", 32'(seg4), 32'h0FFF_FFFF);
    check("rst_seg3", 32'(seg3), 32'h001F_FFFF);
    @(posedge clk); #1;

    go4(10'd1023, 16'h1023, {7'h79, 7'h40, 7'h24, 7'h30});
    @(negedge clk);
    check("busy_after_accept", 32'(busy4), 32'd1);
    wait_done4("done_1023");
    go4(10'd0, 16'h0000, {LZ, LZ, LZ, 7'h40});
    wait_done4("done_0");
    go4(10'd999, 16'h0999, {LZ, 7'h10, 7'h10, 7'h10});
    wait_done4("done_999");
    @(posedge clk); #1;

    go4(10'd512, 16'h0512, {LZ, 7'h12, 7'h79, 7'h24});
    repeat (2) begin @(posedge clk); #1; end
    start4 = 1'b1; bin4 = 10'd5;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done4("done_512");
    @(posedge clk); #1;

    go3(10'd1000, 12'h000, {7'h3F, 7'h3F, 7'h3F}, 1'b1);
    wait_done3("done3_1000");
    @(posedge clk); #1;
    go3(10'd999, 12'h999, {7'h10, 7'h10, 7'h10}, 1'b0);
    wait_done3("done3_999");
    @(posedge clk); #1;

    start4 = 1'b1; bin4 = 10'd777;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; start4 = 1'b1; bin4 = 10'd42;
    @(posedge clk); #1;
    rst = 1'b0; start4 = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_bcd", 32'(bcd4), 32'd0);
    check("abort_seg", 32'(seg4), 32'h0FFF_FFFF);
    check("abort_bcd3", 32'(bcd3), 32'd0);
    repeat (15) begin @(posedge clk); #1; end
    check("abort_still_idle", 32'(busy4), 32'd0);

    go4(10'd42, 16'h0042, {LZ, LZ, 7'h19, 7'h24});
    wait_done4("done_42");
    repeat (3) begin @(posedge clk); #1; end
    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q3_drained", 32'(q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
